spi_mem_bridge: RTL and testbench
=================================

# spi_mem_bridge

Parametrised serial front-end that loads and reads back the processor's instruction and data memories over a chip-select/MOSI/MISO link. It sits between the chip pins and the memory write ports, where a plain write-only shift buffer used to be. It adds N_CH channels, MISO read-back, frame checking and error reporting. It samples one bit per clk edge and drives one synchronous write pulse per completed write frame.

## Interface
- DATA_W, 8, memory word width
- ADDR_W, 4, memory address width
- N_CH, 2, number of memories/chip selects (ch0 = icache, ch1 = dcache)
- clk  in  1  system clock; all sampling on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cs_n  in  N_CH  per-channel chip select, active-low, synchronous to clk
- mosi  in  1  serial data in, MSB first
- proc_en  in  1  processor running; blocks new frames
- miso  out  1  serial read-back data
- mem_addr  out  ADDR_W  registered address to the selected memory
- mem_wdata  out  DATA_W  registered write data
- mem_we  out  N_CH  one-hot write strobe, one cycle
- mem_rdata  in  N_CH*DATA_W  combinational read data; channel c at bits [c*DATA_W +: DATA_W]
- busy  out  1  high whenever state != IDLE
- frame_err  out  1  one-cycle pulse on an aborted or illegal frame

## Operation
- Frame format, MSB first: cmd bit (1 = write, 0 = read), then ADDR_W address bits.
  - Write: DATA_W data bits follow; total 1+ADDR_W+DATA_W bits.
  - Read: 1 turnaround bit (value ignored), then DATA_W bits on miso.
- Channel select: "active" means exactly one cs_n bit low and proc_en low. The active channel index is latched at the frame's first bit.
- States:
  - IDLE: wait for an active channel. The first bit is sampled on the same edge that sees it.
  - HDR: capture cmd and address. After the last address bit, go to WDATA if cmd=1, else TURN.
  - WDATA: capture DATA_W bits. After the last one, go to COMMIT.
  - COMMIT: mem_we[ch] high for exactly this one cycle, then go to HOLD.
  - TURN: load mem_rdata[ch] into the tx shift register, then go to RDATA.
  - RDATA: shift tx out over DATA_W edges, then go to HOLD.
  - HOLD: ignore all bits until every cs_n is high, then go to IDLE.
- Bit counter width is clog2(1+ADDR_W+DATA_W+1). It clears on entry to IDLE.
- Abort conditions, checked in HDR, WDATA, TURN and RDATA:
  - latched cs_n goes high early;
  - another cs_n goes low;
  - proc_en rises.
  - On abort: frame_err pulses on the next cycle, no write occurs, and the state goes to HOLD.
- A second chip select low in IDLE is not a frame. No error is raised; the state stays in IDLE.
- Registers and their update points:
  - mem_addr updates on the last address edge and holds until the next frame's last address edge.
  - mem_wdata updates on the last data edge.

## Timing
- Reset values: every output is 0, state IDLE, counter 0, tx register 0. Reset is asynchronous and may occur mid-frame; it never produces a mem_we.
- Write frame, first bit at edge E0: last data bit at E0+ADDR_W+DATA_W. mem_we is high in the cycle after that edge, i.e. 1 cycle latency.
- Read frame, last address bit at edge EA:
  - mem_addr is valid from EA.
  - The edge at EA+1 is the turnaround; tx loads here.
  - miso = data bit DATA_W-1 from EA+1 to EA+2, then bit DATA_W-1-i from EA+1+i to EA+2+i.
  - miso returns to 0 after the last bit and in every state except RDATA.
- Back-to-back frames need at least one cycle with all cs_n high between them (HOLD to IDLE).
- busy rises with the first sampled bit and falls on the edge leaving HOLD.
- mem_we is never asserted while proc_en = 1.

## Test plan
- Write ch0, addr 5, data 0xA5; mosi = 1_0101_10100101 over 13 edges → mem_we = 01 for 1 cycle, mem_addr = 5, mem_wdata = 0xA5; busy drops after cs_n rises.
- Read ch1, addr 3, with mem_rdata[ch1] = 0x3C; send 1+4 header bits, then 1 turnaround bit → miso = 0,0,1,1,1,1,0,0 on the following 8 cycles; mem_we stays 0.
- Short write: cs_n[0] rises after 9 bits → frame_err pulses once, no mem_we; the next full frame writes correctly.
- Both cs_n low mid-frame at bit 6 → abort, frame_err pulses; both cs_n low in IDLE → no busy, no error.
- proc_en = 1 with cs_n[1] low → busy stays 0, no write; proc_en rising at bit 10 of a write → frame_err, no write.
- rst_n low at bit 11 of a write → all outputs 0 immediately, no mem_we; after release, a frame to addr 15 with data 0xFF writes (address wrap-edge value).

Source files
------------

// File: rtl/spi_mem_bridge_if.sv
// spi_mem_bridge_if
//   Pin-side serial link and memory-side port bundle for spi_mem_bridge.
//   slave  : bridge view (takes chip selects, mosi, proc_en, memory read data;
//            drives miso, memory address/data/strobes, busy, frame_err).
//   master : driver view (chip pins plus the memories feeding mem_rdata).
//   Signals:
//     cs_n[N_CH]            per-channel chip select, active-low
//     mosi                  serial data in, MSB first
//     proc_en               processor running; blocks new frames
//     miso                  serial read-back data
//     mem_addr[ADDR_W]      registered memory address
//     mem_wdata[DATA_W]     registered write data
//     mem_we[N_CH]          one-hot single-cycle write strobe
//     mem_rdata[N_CH*DATA_W] read data, channel c at [c*DATA_W +: DATA_W]
//     busy                  bridge not idle
//     frame_err             single-cycle pulse on an aborted frame
interface spi_mem_bridge_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int N_CH   = 2
);
   logic [N_CH-1:0]        cs_n;
   logic                   mosi;
   logic                   proc_en;
   logic                   miso;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic [N_CH-1:0]        mem_we;
   logic [N_CH*DATA_W-1:0] mem_rdata;
   logic                   busy;
   logic                   frame_err;

   modport slave (
      input  cs_n, mosi, proc_en, mem_rdata,
      output miso, mem_addr, mem_wdata, mem_we, busy, frame_err
   );

   modport master (
      output cs_n, mosi, proc_en, mem_rdata,
      input  miso, mem_addr, mem_wdata, mem_we, busy, frame_err
   );
endinterface

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge
//   Serial loader / read-back bridge between the chip-select/MOSI/MISO pins
//   and N_CH memory ports (ch0 = icache, ch1 = dcache). One bit is sampled per
//   rising clk edge. Frame: cmd bit (1 = write), ADDR_W address bits, then
//   either DATA_W write bits or one turnaround bit plus DATA_W bits on miso.
//   Ports:
//     clk    system clock, rising-edge sampling
//     rst_n  asynchronous active-low reset
//     bus    spi_mem_bridge_if.slave (pins, memory ports, busy, frame_err)
module spi_mem_bridge #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int N_CH   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_mem_bridge_if.slave bus
);

   localparam int CNT_W = $clog2(1 + ADDR_W + DATA_W + 1);
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

   // Counter value seen on the edge that carries the final bit of each phase.
   localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] LAST_WDATA = CNT_W'(ADDR_W + DATA_W);
   localparam logic [CNT_W-1:0] LAST_RDATA = CNT_W'(ADDR_W + 1 + DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_WDATA,
      S_COMMIT,
      S_TURN,
      S_RDATA,
      S_HOLD
   } state_t;

   state_t            state, state_n;
   logic              abort;

   logic [CNT_W-1:0]  cnt;
   logic [CH_W-1:0]   ch;
   logic              cmd;
   logic [ADDR_W-2:0] addr_sh;
   logic [DATA_W-2:0] data_sh;
   logic [DATA_W-1:0] tx;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;

   logic [N_CH-1:0]   cs_low;
   logic              one_low;
   logic              active;
   logic [CH_W-1:0]   low_idx;
   logic [N_CH-1:0]   ch_mask;
   logic              abort_cond;
   logic [ADDR_W-1:0] addr_nx;
   logic [DATA_W-1:0] data_nx;

   // ---------------------------------------------------------------------
   // Chip-select decode
   // ---------------------------------------------------------------------
   assign cs_low  = ~bus.cs_n;
   // Exactly one select low: non-zero and a power of two.
   assign one_low = (cs_low != '0) && ((cs_low & (cs_low - N_CH'(1))) == '0);
   assign active  = one_low && !bus.proc_en;

   always_comb begin
      low_idx = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (cs_low[i]) begin
            low_idx = CH_W'(i);
         end
      end
   end

   assign ch_mask    = N_CH'(1) << ch;
   assign abort_cond = bus.cs_n[ch] | (|(cs_low & ~ch_mask)) | bus.proc_en;

   assign addr_nx = {addr_sh, bus.mosi};
   assign data_nx = {data_sh, bus.mosi};

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_n = state;
      abort   = 1'b0;
      case (state)
         S_IDLE: begin
            if (active) begin
               state_n = S_HDR;
            end
         end
         S_HDR: begin
            if (abort_cond) begin
               abort   = 1'b1;
               state_n = S_HOLD;
            end else if (cnt == LAST_ADDR) begin
               state_n = cmd ? S_WDATA : S_TURN;
            end
         end
         S_WDATA: begin
            if (abort_cond) begin
               abort   = 1'b1;
               state_n = S_HOLD;
            end else if (cnt == LAST_WDATA) begin
               state_n = S_COMMIT;
            end
         end
         S_COMMIT: begin
            state_n = S_HOLD;
         end
         S_TURN: begin
            if (abort_cond) begin
               abort   = 1'b1;
               state_n = S_HOLD;
            end else begin
               state_n = S_RDATA;
            end
         end
         S_RDATA: begin
            if (abort_cond) begin
               abort   = 1'b1;
               state_n = S_HOLD;
            end else if (cnt == LAST_RDATA) begin
               state_n = S_HOLD;
            end
         end
         S_HOLD: begin
            if (&bus.cs_n) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: counter, shift registers, output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         ch      <= '0;
         cmd     <= 1'b0;
         addr_sh <= '0;
         data_sh <= '0;
         tx      <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= abort;
         case (state)
            S_IDLE: begin
               if (active) begin
                  cmd <= bus.mosi;
                  ch  <= low_idx;
                  cnt <= CNT_W'(1);
               end
            end
            S_HDR: begin
               if (!abort) begin
                  addr_sh <= addr_nx[ADDR_W-2:0];
                  cnt     <= cnt + CNT_W'(1);
                  if (cnt == LAST_ADDR) begin
                     addr_q <= addr_nx;
                  end
               end
            end
            S_WDATA: begin
               if (!abort) begin
                  data_sh <= data_nx[DATA_W-2:0];
                  cnt     <= cnt + CNT_W'(1);
                  if (cnt == LAST_WDATA) begin
                     wdata_q <= data_nx;
                  end
               end
            end
            S_TURN: begin
               if (!abort) begin
                  tx  <= bus.mem_rdata[ch*DATA_W +: DATA_W];
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_RDATA: begin
               if (abort) begin
                  tx <= '0;
               end else begin
                  tx  <= {tx[DATA_W-2:0], 1'b0};
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (&bus.cs_n) begin
                  cnt <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.frame_err = err_q;
   assign bus.busy      = (state != S_IDLE);
   assign bus.miso      = (state == S_RDATA) ? tx[DATA_W-1] : 1'b0;
   // Gated by proc_en so a processor start during COMMIT can never see a write.
   assign bus.mem_we    = ((state == S_COMMIT) && !bus.proc_en) ? ch_mask : '0;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge
//   Scoreboard bench for spi_mem_bridge: write transactions are queued when a
//   frame is driven and retired by a monitor when mem_we fires; read-back bytes
//   are queued and compared with the bits collected from miso.
module tb_spi_mem_bridge;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int N_CH   = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   spi_mem_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH)) bus ();

   spi_mem_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int unsigned       ch;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_exp_t;

   wr_exp_t           wr_q[$];
   logic [DATA_W-1:0] rd_q[$];

   int unsigned n_chk   = 0;
   int unsigned n_pass  = 0;
   int unsigned err_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N_CH-1:0] sel(input int unsigned c);
      logic [N_CH-1:0] v;
      v    = '1;
      v[c] = 1'b0;
      return v;
   endfunction

   function automatic logic [N_CH-1:0] onehot(input int unsigned c);
      logic [N_CH-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   task automatic send_bit(input logic [N_CH-1:0] cs, input logic b);
      @(negedge clk);
      bus.cs_n = cs;
      bus.mosi = b;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: retire queued writes on mem_we, count frame_err cycles.
   initial begin
      wr_exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_we !== '0) begin
            if (wr_q.size() == 0) begin
               check("we_unexpected", 32'(bus.mem_we), 32'd0);
            end else begin
               e = wr_q.pop_front();
               check("we_strobe", 32'(bus.mem_we), 32'(onehot(e.ch)));
               check("we_addr", 32'(bus.mem_addr), 32'(e.addr));
               check("we_data", 32'(bus.mem_wdata), 32'(e.data));
               check("we_proc_en", 32'(bus.proc_en), 32'd0);
            end
         end
         if (bus.frame_err === 1'b1) begin
            err_cnt++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   task automatic wr_frame(input int unsigned c, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
      logic [ADDR_W+DATA_W:0] w;
      wr_exp_t                e;
      w      = {1'b1, a, d};
      e.ch   = c;
      e.addr = a;
      e.data = d;
      wr_q.push_back(e);
      for (int k = 0; k <= ADDR_W + DATA_W; k++) begin
         send_bit(sel(c), w[ADDR_W+DATA_W-k]);
         if (k == 1) check("busy_rise", 32'(bus.busy), 32'd1);
      end
      @(posedge clk);
      #1;
      check("we_latency", 32'(bus.mem_we), 32'(onehot(c)));
      check("wr_addr", 32'(bus.mem_addr), 32'(a));
      check("wr_wdata", 32'(bus.mem_wdata), 32'(d));
      @(negedge clk);
      bus.cs_n = '1;
      @(posedge clk);
      #1;
      check("busy_hold", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      check("busy_fall", 32'(bus.busy), 32'd0);
      idle(1);
   endtask

   task automatic rd_frame(input int unsigned c, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
      logic [ADDR_W:0]   h;
      logic [DATA_W-1:0] rx;
      logic [DATA_W-1:0] e;
      h = {1'b0, a};
      bus.mem_rdata[c*DATA_W +: DATA_W] = d;
      rd_q.push_back(d);
      for (int k = 0; k <= ADDR_W; k++) begin
         send_bit(sel(c), h[ADDR_W-k]);
      end
      send_bit(sel(c), 1'b1);
      rx = '0;
      for (int i = 0; i < DATA_W; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) check("rd_addr", 32'(bus.mem_addr), 32'(a));
         rx = {rx[DATA_W-2:0], bus.miso};
      end
      @(posedge clk);
      #1;
      check("miso_end", 32'(bus.miso), 32'd0);
      check("rd_busy", 32'(bus.busy), 32'd1);
      e = rd_q.pop_front();
      check("rd_data", 32'(rx), 32'(e));
      @(negedge clk);
      bus.cs_n = '1;
      idle(2);
   endtask

   initial begin
      int unsigned            e0;
      logic [ADDR_W+DATA_W:0] w;

      bus.cs_n      = '1;
      bus.mosi      = 1'b0;
      bus.proc_en   = 1'b0;
      bus.mem_rdata = '0;

      #2 rst_n = 1'b0;
      idle(3);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_we", 32'(bus.mem_we), 32'd0);
      check("rst_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
      check("rst_miso", 32'(bus.miso), 32'd0);
      check("rst_err", 32'(bus.frame_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      wr_frame(0, 4'd5, 8'hA5);
      rd_frame(1, 4'd3, 8'h3C);
      rd_frame(0, 4'd5, 8'h96);

      // Short write: select released after 9 bits.
      e0 = err_cnt;
      w  = {1'b1, 4'd7, 8'hC3};
      for (int k = 0; k < 9; k++) send_bit(sel(0), w[ADDR_W+DATA_W-k]);
      send_bit('1, 1'b0);
      idle(4);
      check("short_err", err_cnt - e0, 32'd1);
      check("short_busy", 32'(bus.busy), 32'd0);
      wr_frame(0, 4'd9, 8'h5A);

      // Second select joins mid-frame at bit 6.
      e0 = err_cnt;
      w  = {1'b1, 4'hA, 8'h0F};
      for (int k = 0; k < 6; k++) send_bit(sel(1), w[ADDR_W+DATA_W-k]);
      send_bit(2'b00, w[ADDR_W+DATA_W-6]);
      send_bit('1, 1'b0);
      idle(4);
      check("dual_err", err_cnt - e0, 32'd1);

      // Both selects low while idle: not a frame.
      e0 = err_cnt;
      for (int k = 0; k < 5; k++) begin
         send_bit(2'b00, 1'b1);
         check("dual_idle_busy", 32'(bus.busy), 32'd0);
      end
      send_bit('1, 1'b0);
      idle(3);
      check("dual_idle_err", err_cnt - e0, 32'd0);

      // Processor running: selects are ignored.
      e0 = err_cnt;
      @(negedge clk);
      bus.proc_en = 1'b1;
      w = {1'b1, 4'd2, 8'h77};
      for (int k = 0; k <= ADDR_W + DATA_W; k++) begin
         send_bit(sel(1), w[ADDR_W+DATA_W-k]);
         check("blk_busy", 32'(bus.busy), 32'd0);
      end
      send_bit('1, 1'b0);
      bus.proc_en = 1'b0;
      idle(3);
      check("blk_err", err_cnt - e0, 32'd0);

      // proc_en rises on bit 10 of a write.
      e0 = err_cnt;
      w  = {1'b1, 4'hC, 8'h81};
      for (int k = 0; k < 10; k++) send_bit(sel(1), w[ADDR_W+DATA_W-k]);
      send_bit(sel(1), w[ADDR_W+DATA_W-10]);
      bus.proc_en = 1'b1;
      send_bit('1, 1'b0);
      bus.proc_en = 1'b0;
      idle(4);
      check("proc_err", err_cnt - e0, 32'd1);
      check("proc_addr", 32'(bus.mem_addr), 32'hC);

      // Reset asserted at bit 11 of a write.
      w = {1'b1, 4'd6, 8'h33};
      for (int k = 0; k < 11; k++) send_bit(sel(0), w[ADDR_W+DATA_W-k]);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_we", 32'(bus.mem_we), 32'd0);
      check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
      check("mid_rst_wdata", 32'(bus.mem_wdata), 32'd0);
      check("mid_rst_miso", 32'(bus.miso), 32'd0);
      bus.cs_n = '1;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      wr_frame(1, 4'hF, 8'hFF);
      rd_frame(0, 4'hF, 8'h81);

      idle(3);
      check("wr_q_empty", 32'(wr_q.size()), 32'd0);
      check("rd_q_empty", 32'(rd_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
